// File: rtl/route_pkg.sv
// Shared types and helpers for the route_select position-check stage:
// port-width sizing, priority find-set and FIFO occupancy states.
package route_pkg;

  // Upper bound on the relative address width the helpers below can scan.
  localparam int MAX_ADDR_W = 64;

  typedef enum logic [1:0] {
    FIFO_EMPTY,
    FIFO_PARTIAL,
    FIFO_FULL
  } fifo_state_e;

  // Width of an index into n items, never narrower than one bit.
  function automatic int port_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index of the lowest (prio_msb=0) or highest (prio_msb=1) set bit among
  // the low `width` bits of vec; 0 when no bit is set.
  function automatic int find_set(input logic [MAX_ADDR_W-1:0] vec,
                                  input int                    width,
                                  input logic                  prio_msb);
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    for (int i = 0; i < MAX_ADDR_W; i++) begin
      if (i < width && vec[i] && (prio_msb || !found)) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/route_fifo.sv
// Generic DEPTH-entry synchronous FIFO of element type T with registered
// full/empty flags driven by an occupancy state machine.
module route_fifo
  import route_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int PTR_W = port_w(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  fifo_state_e      state_q, state_d;
  logic             push_ok;
  logic             pop_ok;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (state_q == FIFO_FULL);
  assign empty   = (state_q == FIFO_EMPTY);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned and infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (push_ok) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: ;
    endcase
    if (count_d == '0)                 state_d = FIFO_EMPTY;
    else if (count_d == OCC_W'(DEPTH)) state_d = FIFO_FULL;
    else                               state_d = FIFO_PARTIAL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= FIFO_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  // NOTE: storage is deliberately not reset; stale entries are never visible because empty gates the outputs upstream.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/route_select.sv
// Position-check stage: decodes a relative address into core/port delivery,
// buffers decisions in a FIFO and keeps saturating per-destination counters.
module route_select
  import route_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter bit PRIO_MSB = 1'b0,
  parameter int DEPTH    = 2,
  parameter int CNT_W    = 16,
  localparam int PORT_W  = port_w(ADDR_W)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_W-1:0]       in_addr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_core,
  output logic [PORT_W-1:0]       out_port,
  output logic [ADDR_W-1:0]       out_addr,
  input  logic                    clr_stats,
  output logic [CNT_W-1:0]        core_cnt,
  output logic [ADDR_W*CNT_W-1:0] port_cnt
);

  typedef struct packed {
    logic              core;
    logic [PORT_W-1:0] port;
    logic [ADDR_W-1:0] addr;
  } route_t;

  route_t     dec;
  route_t     head;
  int         sel_idx;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;

  logic [CNT_W-1:0] core_cnt_q, core_cnt_d;
  logic [CNT_W-1:0] port_cnt_q [ADDR_W];
  logic [CNT_W-1:0] port_cnt_d [ADDR_W];

  always_comb begin
    dec     = '0;
    sel_idx = 0;
    if (in_addr == '0) begin
      dec.core = 1'b1;
    end else begin
      sel_idx  = find_set(MAX_ADDR_W'(in_addr), ADDR_W, PRIO_MSB);
      dec.port = PORT_W'(sel_idx);
      dec.addr = in_addr & ~(ADDR_W'(1) << sel_idx);
    end
  end

  // in_ready comes from the registered full flag, so out_ready never reaches it.
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  route_fifo #(
    .DEPTH (DEPTH),
    .T     (route_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (dec),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_core  = out_valid && head.core;
  assign out_port  = out_valid ? head.port : '0;
  assign out_addr  = out_valid ? head.addr : '0;

  always_comb begin
    core_cnt_d = core_cnt_q;
    for (int i = 0; i < ADDR_W; i++) port_cnt_d[i] = port_cnt_q[i];
    if (clr_stats) begin
      core_cnt_d = '0;
      for (int i = 0; i < ADDR_W; i++) port_cnt_d[i] = '0;
    end else if (pop) begin
      if (head.core) begin
        if (core_cnt_q != '1) core_cnt_d = core_cnt_q + CNT_W'(1);
      end else begin
        for (int i = 0; i < ADDR_W; i++) begin
          if (head.port == PORT_W'(i) && port_cnt_q[i] != '1)
            port_cnt_d[i] = port_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_cnt_q <= '0;
      for (int i = 0; i < ADDR_W; i++) port_cnt_q[i] <= '0;
    end else begin
      core_cnt_q <= core_cnt_d;
      for (int i = 0; i < ADDR_W; i++) port_cnt_q[i] <= port_cnt_d[i];
    end
  end

  assign core_cnt = core_cnt_q;
  for (genvar g = 0; g < ADDR_W; g++) begin : g_cnt
    assign port_cnt[g*CNT_W +: CNT_W] = port_cnt_q[g];
  end

endmodule

// File: tb/tb_route_select.sv
// Scoreboard bench for route_select: an LSB-priority wide-counter instance and
// an MSB-priority 2-bit-counter instance share one stimulus stream.
module tb_route_select;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_addr;
  logic        out_ready;
  logic        clr_stats;

  logic        in_ready0, out_valid0, out_core0;
  logic [1:0]  out_port0;
  logic [3:0]  out_addr0;
  logic [15:0] core_cnt0;
  logic [63:0] port_cnt0;

  logic        in_ready1, out_valid1, out_core1;
  logic [1:0]  out_port1;
  logic [3:0]  out_addr1;
  logic [1:0]  core_cnt1;
  logic [7:0]  port_cnt1;

  typedef struct packed {
    logic       core;
    logic [1:0] p0;
    logic [3:0] a0;
    logic [1:0] p1;
    logic [3:0] a1;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_pops  = 0;
  int   m_core0;
  int   m_port0 [4];
  logic [1:0] m_core1;
  logic [1:0] m_port1 [4];

  always #5 clk = ~clk;

  route_select #(.ADDR_W(4), .PRIO_MSB(1'b0), .DEPTH(2), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_addr(in_addr), .out_valid(out_valid0), .out_ready(out_ready),
    .out_core(out_core0), .out_port(out_port0), .out_addr(out_addr0),
    .clr_stats(clr_stats), .core_cnt(core_cnt0), .port_cnt(port_cnt0)
  );

  route_select #(.ADDR_W(4), .PRIO_MSB(1'b1), .DEPTH(2), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_addr(in_addr), .out_valid(out_valid1), .out_ready(out_ready),
    .out_core(out_core1), .out_port(out_port1), .out_addr(out_addr1),
    .clr_stats(clr_stats), .core_cnt(core_cnt1), .port_cnt(port_cnt1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Reference decode: scan upward for the lowest set bit, downward for the highest.
  function automatic exp_t model(input logic [3:0] a);
    exp_t e;
    int   lo;
    int   hi;
    e = '0;
    if (a == 4'b0000) begin
      e.core = 1'b1;
    end else begin
      lo = 0;
      while (!a[lo]) lo++;
      hi = 3;
      while (!a[hi]) hi--;
      e.p0 = 2'(lo);
      e.a0 = a;
      e.a0[lo] = 1'b0;
      e.p1 = 2'(hi);
      e.a1 = a;
      e.a1[hi] = 1'b0;
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard on every handshake and tracks expected counters.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      m_core0 = 0;
      m_core1 = '0;
      for (int i = 0; i < 4; i++) begin
        m_port0[i] = 0;
        m_port1[i] = '0;
      end
    end else begin
      if (out_valid0 && out_ready) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_out: got core=%0b port=%0d addr=%0h with empty scoreboard",
                   out_core0, out_port0, out_addr0);
        end else begin
          e = exp_q.pop_front();
          check("out_valid1", {63'd0, out_valid1}, 64'd1);
          check("out_core0", {63'd0, out_core0}, {63'd0, e.core});
          check("out_port0", {62'd0, out_port0}, {62'd0, e.p0});
          check("out_addr0", {60'd0, out_addr0}, {60'd0, e.a0});
          check("out_core1", {63'd0, out_core1}, {63'd0, e.core});
          check("out_port1", {62'd0, out_port1}, {62'd0, e.p1});
          check("out_addr1", {60'd0, out_addr1}, {60'd0, e.a1});
          if (e.core) begin
            m_core0++;
            if (m_core1 != 2'd3) m_core1++;
          end else begin
            m_port0[e.p0]++;
            if (m_port1[e.p1] != 2'd3) m_port1[e.p1]++;
          end
        end
      end
      if (clr_stats) begin
        m_core0 = 0;
        m_core1 = '0;
        for (int i = 0; i < 4; i++) begin
          m_port0[i] = 0;
          m_port1[i] = '0;
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Must be entered 1 time unit after a rising edge; returns likewise.
  task automatic push(input logic [3:0] a, input exp_t e, output int waits);
    in_valid = 1'b1;
    in_addr  = a;
    waits    = 0;
    @(negedge clk);
    while (!in_ready0 && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready0) begin
      n_total++;
      $display("FAIL push_timeout: in_ready stayed 0 for addr %0h", a);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid0 || in_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_total++;
      $display("FAIL %s: drain timeout, %0d entries left", name, exp_q.size());
    end
    sync();
    @(negedge clk);
  endtask

  task automatic check_counts(input string name);
    check({name, "_core0"}, {48'd0, core_cnt0}, 64'(m_core0));
    check({name, "_core1"}, {62'd0, core_cnt1}, {62'd0, m_core1});
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_port0_%0d", name, i), {48'd0, port_cnt0[i*16 +: 16]}, 64'(m_port0[i]));
      check($sformatf("%s_port1_%0d", name, i), {62'd0, port_cnt1[i*2 +: 2]}, {62'd0, m_port1[i]});
    end
  endtask

  initial begin
    int     w;
    int     w3;
    int     total_w;
    int     pops_start;
    time    t_start;
    exp_t   e;
    logic [3:0] a;

    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; out_ready = 1'b0; clr_stats = 1'b0;
    w3 = 0;
    #2;
    check("rst_in_ready", {63'd0, in_ready0}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid0}, 64'd0);
    check("rst_out_core", {63'd0, out_core0}, 64'd0);
    check("rst_out_port", {62'd0, out_port0}, 64'd0);
    check("rst_out_addr", {60'd0, out_addr0}, 64'd0);
    check("rst_cnt", {48'd0, core_cnt0} | port_cnt0, 64'd0);
    #10 rst_n = 1'b1;

    // Core delivery and one-cycle latency.
    out_ready = 1'b1;
    sync();
    check("idle_valid", {63'd0, out_valid0}, 64'd0);
    push(4'b0000, '{core: 1'b1, p0: 2'd0, a0: 4'd0, p1: 2'd0, a1: 4'd0}, w);
    @(negedge clk);
    check("latency_valid", {63'd0, out_valid0}, 64'd1);
    wait_drain("core");
    check("core_cnt_one", {48'd0, core_cnt0}, 64'd1);

    // Priority direction on 1010.
    sync();
    push(4'b1010, '{core: 1'b0, p0: 2'd1, a0: 4'b1000, p1: 2'd3, a1: 4'b0010}, w);
    wait_drain("prio");

    // Stall with DEPTH=2: third address blocked until a pop.
    sync();
    out_ready = 1'b0;
    push(4'b0011, '{core: 1'b0, p0: 2'd0, a0: 4'b0010, p1: 2'd1, a1: 4'b0001}, w);
    push(4'b0110, '{core: 1'b0, p0: 2'd1, a0: 4'b0100, p1: 2'd2, a1: 4'b0010}, w);
    fork
      push(4'b1100, '{core: 1'b0, p0: 2'd2, a0: 4'b1000, p1: 2'd3, a1: 4'b0100}, w3);
    join_none
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", {63'd0, in_ready0}, 64'd0);
      check("stall_valid", {63'd0, out_valid0}, 64'd1);
      check("stall_port0", {62'd0, out_port0}, 64'd0);
      check("stall_addr0", {60'd0, out_addr0}, 64'b0010);
      check("stall_addr1", {60'd0, out_addr1}, 64'b0001);
    end
    sync();
    out_ready = 1'b1;
    wait_drain("stall");
    check("stall_waited", {63'd0, 1'(w3 >= 3)}, 64'd1);

    // Counter clear, then saturation of the 2-bit counters.
    sync();
    clr_stats = 1'b1;
    sync();
    clr_stats = 1'b0;
    @(negedge clk);
    check_counts("clr");
    sync();
    for (int i = 0; i < 5; i++)
      push(4'b0100, '{core: 1'b0, p0: 2'd2, a0: 4'd0, p1: 2'd2, a1: 4'd0}, w);
    wait_drain("sat");
    check("sat_port1_2", {56'd0, port_cnt1}, {56'd0, 8'b00_11_00_00});
    check("sat_port0_2", {48'd0, port_cnt0[47:32]}, 64'd5);
    check_counts("sat");

    // Clear in the same cycle as a pop wins over the increment.
    sync();
    push(4'b0100, '{core: 1'b0, p0: 2'd2, a0: 4'd0, p1: 2'd2, a1: 4'd0}, w);
    clr_stats = 1'b1;
    sync();
    clr_stats = 1'b0;
    wait_drain("clr_pop");
    check("clr_pop_port0", {48'd0, port_cnt0[47:32]}, 64'd0);
    check("clr_pop_port1", {62'd0, port_cnt1[5:4]}, 64'd0);

    // Back-to-back stream, one decision per cycle.
    sync();
    total_w    = 0;
    pops_start = n_pops;
    t_start    = $time;
    for (int i = 0; i < 100; i++) begin
      a = 4'($urandom_range(0, 15));
      e = model(a);
      push(a, e, w);
      total_w += w;
    end
    check("stream_cycles", 64'(($time - t_start) / 10), 64'd100);
    check("stream_waits", 64'(total_w), 64'd0);
    wait_drain("stream");
    check("stream_pops", 64'(n_pops - pops_start), 64'd100);
    check_counts("stream");

    // Reset with two entries buffered discards them.
    sync();
    out_ready = 1'b0;
    push(4'b0101, '{core: 1'b0, p0: 2'd0, a0: 4'b0100, p1: 2'd2, a1: 4'b0001}, w);
    push(4'b1000, '{core: 1'b0, p0: 2'd3, a0: 4'd0, p1: 2'd3, a1: 4'd0}, w);
    @(negedge clk);
    check("pre_rst_valid", {63'd0, out_valid0}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid0", {63'd0, out_valid0}, 64'd0);
    check("mid_rst_valid1", {63'd0, out_valid1}, 64'd0);
    check("mid_rst_ready0", {63'd0, in_ready0}, 64'd1);
    check("mid_rst_ready1", {63'd0, in_ready1}, 64'd1);
    check("mid_rst_cnt0", {48'd0, core_cnt0} | port_cnt0, 64'd0);
    check("mid_rst_cnt1", {54'd0, core_cnt1, port_cnt1}, 64'd0);
    exp_q.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_valid", {63'd0, out_valid0}, 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
